cpu_pio_out_pulse: RTL and testbench
====================================

// Module: cpu_pio_out_pulse
// PURPOSE
//  Avalon-MM slave output PIO: drives WIDTH-bit out_port from a CPU-writable data register.
//  Adds atomic bit set/clear and a timed one-shot pulse engine that inverts selected bits for a programmable cycle count.
//  Output-side counterpart of the input/edge-capture PIO; sits on the same system interconnect, driving LEDs/strobes.
// PARAMETERS
//  WIDTH        8   out_port / data register width (1..32)
//  PULSE_W      16  pulse length counter width (1..16)
//  RESET_VALUE  0   data register value after reset (WIDTH bits)
// PORTS
//  clk        in   1       system clock
//  reset_n    in   1       asynchronous active-low reset
//  address    in   3       register select
//  chipselect in   1       slave select
//  write_n    in   1       active-low write strobe, qualified by chipselect
//  writedata  in   32      write data
//  readdata   out  32      registered read data
//  out_port   out  WIDTH   external output = data_reg ^ pulse_mask
// BEHAVIOUR
//  Reset (async, reset_n=0): data_reg=RESET_VALUE, pulse_len=0, pulse_mask=0, cnt=0, readdata=0, out_port=RESET_VALUE.
//  Write strobe wr = chipselect & ~write_n; writedata bits above WIDTH/PULSE_W are ignored.
//  Register map:
//   0 DATA     R/W  data_reg <= writedata[WIDTH-1:0]
//   1 PLEN     R/W  pulse_len <= writedata[PULSE_W-1:0]; affects next pulse start only
//   2 PULSE    W: start pulse on bits set in writedata; R: current pulse_mask
//   3 STATUS   RO   bit0 busy (cnt!=0); bits[16+PULSE_W-1:16] = cnt; rest 0
//   4 OUTSET   WO   data_reg <= data_reg | writedata[WIDTH-1:0]; reads 0
//   5 OUTCLR   WO   data_reg <= data_reg & ~writedata[WIDTH-1:0]; reads 0
//   6,7        reserved: writes ignored, reads 0
//  Read: readdata registered every clk from address (no chipselect qualification), 1-cycle latency, upper bits 0.
//  out_port: combinational XOR of registered data_reg and pulse_mask; no glitch path from bus inputs.
//   A write sampled at edge k is visible on out_port after edge k.
//  Pulse engine (states IDLE: cnt==0, ACTIVE: cnt!=0):
//   - PULSE write with writedata[WIDTH-1:0]!=0 and pulse_len!=0: pulse_mask <= pulse_mask | wdata; cnt <= pulse_len.
//   - PULSE write with zero mask or pulse_len==0: no effect (state unchanged).
//   - ACTIVE, no restart: cnt==1 -> cnt<=0, pulse_mask<=0 (-> IDLE); else cnt<=cnt-1.
//   - Net: a pulse started with pulse_len=N inverts the masked bits for exactly N cycles.
//   - Restart while ACTIVE: new bits OR'd in, cnt reloads to pulse_len (restart wins over decrement/expiry same cycle).
//  DATA/OUTSET/OUTCLR writes during ACTIVE update data_reg immediately; pulse inversion still applied on top.
//  PLEN write during ACTIVE does not alter running cnt.
//  No wrap: cnt never decrements below 0; pulse_len max = 2^PULSE_W-1.
//  Reset mid-pulse: mask and cnt cleared immediately (async); out_port returns to RESET_VALUE.
// TESTING
//  1 Reset: assert reset_n=0 mid-run -> out_port=0x00, readdata=0, STATUS=0 immediately.
//  2 DATA write 0xA5, OUTSET 0x0A, OUTCLR 0x81 -> out_port 0xA5, 0xAF, 0x2E; DATA read returns 0x2E one cycle after address.
//  3 PLEN=4, DATA=0x00, PULSE=0x03 -> out_port=0x03 for exactly 4 cycles then 0x00; STATUS busy=1, cnt 4,3,2,1 then 0.
//  4 PLEN=5, pulse 0x01, after 3 cycles pulse 0x10 -> mask 0x11, cnt reloads 5; both bits drop together 5 cycles later.
//  5 PLEN=0 then PULSE=0xFF -> no change on out_port, STATUS=0; PULSE=0x00 with PLEN=3 -> no effect.
//  6 DATA=0xF0, PLEN=3, PULSE=0x0F, DATA=0x00 mid-pulse -> out_port 0xFF -> 0x0F until expiry -> 0x00; read addr 6 -> 0.

Source files
------------

// File: rtl/cpu_pio_out_pulse.sv
// Avalon-MM output PIO: CPU-writable data register with atomic set/clear and a
// timed one-shot pulse engine that inverts selected output bits for a programmable cycle count.
module cpu_pio_out_pulse #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      PULSE_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] AddrData   = 3'd0;
  localparam logic [2:0] AddrPlen   = 3'd1;
  localparam logic [2:0] AddrPulse  = 3'd2;
  localparam logic [2:0] AddrStatus = 3'd3;
  localparam logic [2:0] AddrOutSet = 3'd4;
  localparam logic [2:0] AddrOutClr = 3'd5;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  logic               wr;
  logic               start;
  logic               busy;
  logic [WIDTH-1:0]   wmask;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [PULSE_W-1:0] plen_q, plen_d;
  logic [PULSE_W-1:0] cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  state_e             state_q, state_d;
  logic               unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wmask        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // A zero mask or zero length must leave the engine untouched, including a running pulse.
  assign start = wr && (address == AddrPulse) && (wmask != '0) && (plen_q != '0);

  // CPU-visible data and length registers
  always_comb begin
    data_d = data_q;
    plen_d = plen_q;
    if (wr) begin
      case (address)
        AddrData:   data_d = wmask;
        AddrPlen:   plen_d = writedata[PULSE_W-1:0];
        AddrOutSet: data_d = data_q | wmask;
        AddrOutClr: data_d = data_q & ~wmask;
        default:    ;
      endcase
    end
  end

  // Pulse engine: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  // Pulse engine: next state; a restart wins over decrement and expiry in the same cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    if (start) begin
      state_d = StActive;
      cnt_d   = plen_q;
      mask_d  = mask_q | wmask;
    end else begin
      unique case (state_q)
        StIdle: ;
        StActive: begin
          if (cnt_q == PULSE_W'(1)) begin
            state_d = StIdle;
            cnt_d   = '0;
            mask_d  = '0;
          end else begin
            cnt_d = cnt_q - PULSE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Pulse engine: outputs, built only from registers so bus inputs cannot glitch out_port
  always_comb begin
    out_port = data_q ^ mask_q;
    busy     = (state_q == StActive);
  end

  // Read mux, sampled every cycle regardless of chipselect
  always_comb begin
    rdata_d = '0;
    case (address)
      AddrData:   rdata_d[WIDTH-1:0] = data_q;
      AddrPlen:   rdata_d[PULSE_W-1:0] = plen_q;
      AddrPulse:  rdata_d[WIDTH-1:0] = mask_q;
      AddrStatus: begin
        rdata_d[0]          = busy;
        rdata_d[16+:PULSE_W] = cnt_q;
      end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE;
      plen_q  <= '0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      plen_q  <= plen_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;

  busy_matches_cnt: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == StActive) == (cnt_q != '0));

endmodule

// File: tb/tb_cpu_pio_out_pulse.sv
// Scoreboard bench for cpu_pio_out_pulse: stimulus queues expected out_port/readdata values
// tagged with the cycle they are due; a negedge monitor pops and compares them.
module tb_cpu_pio_out_pulse;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  cpu_pio_out_pulse #(
    .WIDTH      (8),
    .PULSE_W    (16),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          is_rd;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: compare every entry due this cycle, flag any that slipped past
  always @(negedge clk) begin
    exp_t keep[$];
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        if (sb[i].is_rd) cmp(sb[i].name, readdata, sb[i].val);
        else             cmp(sb[i].name, {24'h0, out_port}, sb[i].val);
      end else if (sb[i].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: missed at cycle %0d", sb[i].name, sb[i].cyc);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic exp_out(input int ofs, input logic [31:0] v, input string name);
    sb.push_back('{cyc + ofs, 1'b0, v, name});
  endtask

  task automatic exp_rd(input int ofs, input logic [31:0] v, input string name);
    sb.push_back('{cyc + ofs, 1'b1, v, name});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address    = a;
    chipselect = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    idle(2);
    cmp("reset_out", {24'h0, out_port}, 32'h0);
    cmp("reset_rd", readdata, 32'h0);
    reset_n = 1'b1;

    // Data register with atomic set/clear
    exp_out(1, 32'hA5, "data_a5");
    wr(3'd0, 32'hFFFF_FFA5);
    exp_out(1, 32'hAF, "outset");
    wr(3'd4, 32'h0A);
    exp_out(1, 32'h2E, "outclr");
    wr(3'd5, 32'h81);
    exp_rd(1, 32'h2E, "rd_data");
    rd(3'd0);
    exp_rd(1, 32'h0, "rd_outset_zero");
    rd(3'd4);
    exp_rd(1, 32'h0, "rd_status_idle");
    rd(3'd3);

    // Basic pulse: PLEN=4 inverts 0x03 for exactly 4 cycles
    wr(3'd1, 32'h4);
    exp_out(1, 32'h00, "data_zero");
    wr(3'd0, 32'h0);
    for (int i = 1; i <= 4; i++) exp_out(i, 32'h03, "pulse4_on");
    exp_out(5, 32'h00, "pulse4_off");
    exp_rd(2, 32'h0004_0001, "status_c4");
    exp_rd(3, 32'h0003_0001, "status_c3");
    exp_rd(4, 32'h0002_0001, "status_c2");
    exp_rd(5, 32'h0001_0001, "status_c1");
    exp_rd(6, 32'h0000_0000, "status_c0");
    wr(3'd2, 32'h03);
    address = 3'd3;
    idle(6);

    // Restart while active: bits merge, counter reloads
    wr(3'd1, 32'h5);
    for (int i = 1; i <= 3; i++) exp_out(i, 32'h01, "restart_first");
    for (int i = 4; i <= 8; i++) exp_out(i, 32'h11, "restart_merged");
    exp_out(9, 32'h00, "restart_expire");
    exp_rd(5, 32'h0005_0001, "restart_reload");
    exp_rd(6, 32'h0004_0001, "restart_dec");
    wr(3'd2, 32'h01);
    idle(2);
    wr(3'd2, 32'h10);
    address = 3'd3;
    idle(6);

    // Zero length or zero mask: no effect
    for (int i = 1; i <= 3; i++) exp_out(i, 32'h00, "plen0_noeffect");
    exp_rd(3, 32'h0, "plen0_status");
    wr(3'd1, 32'h0);
    wr(3'd2, 32'hFF);
    address = 3'd3;
    idle(2);
    wr(3'd1, 32'h3);
    for (int i = 1; i <= 3; i++) exp_out(i, 32'h00, "mask0_noeffect");
    exp_rd(3, 32'h0, "mask0_status");
    wr(3'd2, 32'h00);
    address = 3'd3;
    idle(2);

    // Data write during pulse; inversion stays on top
    exp_out(1, 32'hF0, "data_f0");
    wr(3'd0, 32'hF0);
    exp_out(1, 32'hFF, "mid_ff");
    exp_out(2, 32'h0F, "mid_0f_a");
    exp_out(3, 32'h0F, "mid_0f_b");
    exp_out(4, 32'h00, "mid_expire");
    exp_out(5, 32'h00, "mid_idle");
    wr(3'd2, 32'h0F);
    wr(3'd0, 32'h00);
    idle(3);
    exp_rd(1, 32'h0, "rd_reserved6");
    rd(3'd6);
    exp_out(1, 32'h00, "wr_reserved7");
    wr(3'd7, 32'hFF);

    // Reset mid-pulse clears everything asynchronously
    exp_out(1, 32'h55, "pre_reset_data");
    wr(3'd0, 32'h55);
    wr(3'd1, 32'd10);
    exp_out(1, 32'h5A, "pre_reset_pulse");
    wr(3'd2, 32'h0F);
    address = 3'd3;
    idle(2);
    #2 reset_n = 1'b0;
    #1;
    cmp("async_reset_out", {24'h0, out_port}, 32'h0);
    cmp("async_reset_rd", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_out(1, 32'h0, "post_reset_out");
    exp_rd(1, 32'h0, "post_reset_status");
    @(negedge clk);
    exp_rd(1, 32'h0, "post_reset_plen");
    rd(3'd1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    foreach (sb[i]) begin
      total++;
      bad++;
      $display("FAIL %s: never checked (due cycle %0d)", sb[i].name, sb[i].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
